// File: rtl/iterative_m_unit.sv
// Multi-cycle RV64M multiply/divide unit: radix-2^MUL_BITS shift-add multiplier, radix-2 restoring divider.
// Optional build macro MDU_EARLY_OUT_EN: early multiply termination and normalised divide.
module iterative_m_unit #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned MUL_BITS = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    input  logic            ack_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned PW = 2 * XLEN;
    localparam int unsigned CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    state_e state_q, state_d;

    logic [CW-1:0]   cnt_q, cnt_n;
    logic [2:0]      op_q;
    logic            word_q, neg_q;
    logic [PW-1:0]   acc_q, mcand_q, acc_n, mcand_n, prod;
    logic [XLEN-1:0] mplier_q, quo_q, rem_q, dvsr_q;
    logic [XLEN-1:0] mplier_n, quo_n, rem_n, mul_res, div_res, iter_res;
    logic [XLEN:0]   rem_sh, diff;
    logic            last, accept, word_in;
`ifdef MDU_EARLY_OUT_EN
    logic            norm_q;
    logic [CW-1:0]   lz;
`endif

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    // W forms keep only the low word and sign-extend bit 31
    function automatic logic [XLEN-1:0] fin(input logic w, input logic [XLEN-1:0] x);
        return w ? sext32(x[31:0]) : x;
    endfunction

`ifdef MDU_EARLY_OUT_EN
    function automatic logic [CW-1:0] clz(input logic [XLEN-1:0] x);
        logic [CW-1:0] n;
        n = CW'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (x[i]) n = CW'(XLEN - 1 - i);
        end
        return n;
    endfunction
`endif

    assign word_in = (XLEN > 32) ? word_i : 1'b0;
    assign accept  = (state_q == IDLE) && start_i && !kill_i;
    assign stall_o = start_i && !done_o && !rst_i;

    // Accept-side decode: operand width/sign, magnitudes and divide special cases
    logic            a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_w, b_w, a_mag, b_mag, min_w, spec_res;
    always_comb begin
        a_sgn = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
        b_sgn = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
        a_w   = a_i;
        b_w   = b_i;
        if (word_in) begin
            a_w = a_sgn ? sext32(a_i[31:0]) : XLEN'(a_i[31:0]);
            b_w = b_sgn ? sext32(b_i[31:0]) : XLEN'(b_i[31:0]);
        end
        a_neg    = a_sgn && a_w[XLEN-1];
        b_neg    = b_sgn && b_w[XLEN-1];
        a_mag    = a_neg ? -a_w : a_w;
        b_mag    = b_neg ? -b_w : b_w;
        min_w    = word_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = op_i[2] && (b_w == '0);
        div_ovf  = op_i[2] && b_sgn && (a_w == min_w) && (b_w == '1);
        spec_res = '0;
        if (div_zero) begin
            spec_res = op_i[1] ? a_w : '1;
        end else if (div_ovf) begin
            spec_res = op_i[1] ? '0 : a_w;
        end
    end

    // One BUSY iteration of both datapaths; the op decides which result is used
    always_comb begin
        acc_n    = acc_q + mcand_q * PW'(mplier_q[MUL_BITS-1:0]);
        mcand_n  = mcand_q << MUL_BITS;
        mplier_n = mplier_q >> MUL_BITS;
        rem_sh   = {rem_q, (word_q ? quo_q[31] : quo_q[XLEN-1])};
        diff     = rem_sh - {1'b0, dvsr_q};
        rem_n    = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
        quo_n    = {quo_q[XLEN-2:0], ~diff[XLEN]};
        cnt_n    = cnt_q - CW'(1);
        last     = (cnt_q == CW'(1));
`ifdef MDU_EARLY_OUT_EN
        lz = '0;
        if (!op_q[2] && (mplier_n == '0)) last = 1'b1;
        if (norm_q) begin
            lz    = clz(quo_q) - (word_q ? CW'(XLEN - 32) : CW'(0));
            quo_n = quo_q << lz;
            rem_n = rem_q;
            cnt_n = (word_q ? CW'(32) : CW'(XLEN)) - lz;
            last  = (cnt_n == '0);
        end
`endif
        prod     = neg_q ? -acc_n : acc_n;
        mul_res  = (op_q == 3'd0) ? prod[XLEN-1:0]
                                  : (word_q ? XLEN'(prod[63:32]) : prod[PW-1:XLEN]);
        div_res  = op_q[1] ? (neg_q ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
        iter_res = fin(word_q, op_q[2] ? div_res : mul_res);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (div_zero || div_ovf) ? DONE : BUSY;
            BUSY:    if (last) state_d = DONE;
            DONE:    if (ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_o  <= (state_d != IDLE);
            done_o  <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            op_q     <= '0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            result_o <= '0;
`ifdef MDU_EARLY_OUT_EN
            norm_q   <= 1'b0;
`endif
        end else if (accept) begin
            op_q     <= op_i;
            word_q   <= word_in;
            neg_q    <= (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
            acc_q    <= '0;
            mcand_q  <= PW'(a_mag);
            mplier_q <= b_mag;
            quo_q    <= a_mag;
            rem_q    <= '0;
            dvsr_q   <= b_mag;
            cnt_q    <= op_i[2] ? (word_in ? CW'(32) : CW'(XLEN))
                                : (word_in ? CW'(32 / MUL_BITS) : CW'(XLEN / MUL_BITS));
`ifdef MDU_EARLY_OUT_EN
            norm_q   <= op_i[2];
`endif
            if (div_zero || div_ovf) result_o <= fin(word_in, spec_res);
        end else if ((state_q == BUSY) && !kill_i) begin
            acc_q    <= acc_n;
            mcand_q  <= mcand_n;
            mplier_q <= mplier_n;
            quo_q    <= quo_n;
            rem_q    <= rem_n;
            cnt_q    <= cnt_n;
`ifdef MDU_EARLY_OUT_EN
            norm_q   <= 1'b0;
`endif
            if (last) result_o <= iter_res;
        end
    end
endmodule

// File: tb/tb_iterative_m_unit.sv
// Scoreboard bench for iterative_m_unit: directed corner cases plus random ops against an arithmetic model.
module tb_iterative_m_unit;
    logic        clk_i, rst_i, start_i, word_i, kill_i, ack_i;
    logic [2:0]  op_i;
    logic [63:0] a_i, b_i, result_o;
    logic        busy_o, stall_o, done_o;

    iterative_m_unit #(.XLEN(64), .MUL_BITS(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .word_i(word_i),
        .a_i(a_i), .b_i(b_i), .kill_i(kill_i), .ack_i(ack_i), .busy_o(busy_o),
        .stall_o(stall_o), .done_o(done_o), .result_o(result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] res;
        int unsigned cyc;
        logic [2:0]  op;
        logic        word;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned cyc;
    int          checks, failures;

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%016h required 0x%016h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // RISC-V M semantics from plain wide arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic word,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, p;
        logic [31:0]  a32, b32, q32, r32;
        logic [63:0]  q64, r64, r;
        logic         as, bs;
        as  = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        bs  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a32 = a[31:0];
        b32 = b[31:0];
        if (!op[2]) begin
            if (word) begin
                pa = {{96{as && a32[31]}}, a32};
                pb = {{96{bs && b32[31]}}, b32};
            end else begin
                pa = {{64{as && a[63]}}, a};
                pb = {{64{bs && b[63]}}, b};
            end
            p = pa * pb;
            if (op == 3'd0) r = word ? {{32{p[31]}}, p[31:0]} : p[63:0];
            else            r = word ? {{32{p[63]}}, p[63:32]} : p[127:64];
        end else if (word) begin
            if (b32 == 32'd0) begin
                q32 = '1; r32 = a32;
            end else if (bs && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = '0;
            end else if (bs) begin
                q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            r = op[1] ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
        end else begin
            if (b == 64'd0) begin
                q64 = '1; r64 = a;
            end else if (bs && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q64 = a; r64 = '0;
            end else if (bs) begin
                q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b);
            end else begin
                q64 = a / b; r64 = a % b;
            end
            r = op[1] ? r64 : q64;
        end
        return r;
    endfunction

    // Cycles from the accept cycle to the first DONE cycle in the fixed-latency build
    function automatic int unsigned latency(input logic [2:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic sgn, zero, ovf;
        sgn  = (op == 3'd4) || (op == 3'd6);
        zero = word ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = sgn && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                            : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (op[2] && (zero || ovf)) return 1;
        if (op[2]) return (word ? 32 : 64) + 1;
        return (word ? 32 : 64) / 8 + 1;
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 6))
            0:       v = '0;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = '1;
            3:       v = 64'($urandom_range(0, 40)) - 64'd20;
            4:       v = {32'h0, 32'h8000_0000};
            5:       v = {32'h0, $urandom};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Monitor: pops one expectation per DONE entry, then watches result stability while DONE holds
    initial begin : monitor
        exp_t        e;
        logic        prev_done;
        logic [63:0] held;
        prev_done = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_done = 1'b0;
            end else begin
                if (done_o && !prev_done) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: result 0x%016h with no pending op (cycle %0d)",
                                 result_o, cyc);
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("result op=%0d w=%0d", e.op, e.word), result_o, e.res);
`ifdef MDU_EARLY_OUT_EN
                        check("latency_bound", 64'(cyc <= e.cyc + 1), 64'd1);
`else
                        check($sformatf("latency op=%0d w=%0d", e.op, e.word), 64'(cyc), 64'(e.cyc));
`endif
                    end
                    held = result_o;
                end else if (done_o) begin
                    check("result_hold", result_o, held);
                end
                prev_done = done_o;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input int hold);
        exp_t e;
        int   n;
        @(negedge clk_i);
        start_i = 1'b1; op_i = op; word_i = word; a_i = a; b_i = b;
        e.res  = model(op, word, a, b);
        e.cyc  = cyc + latency(op, word, a, b);
        e.op   = op;
        e.word = word;
        sb_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
            a_i = {$urandom, $urandom};
            b_i = {$urandom, $urandom};
            if (n == 1 && !done_o) check("stall_while_busy", 64'(stall_o), 64'd1);
        end while (!done_o && n < 200);
        if (!done_o) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: op=%0d no done_o after %0d cycles", op, n);
        end
        check("stall_in_done", 64'(stall_o), 64'd0);
        repeat (hold) @(negedge clk_i);
        ack_i = 1'b1;
        @(negedge clk_i);
        ack_i   = 1'b0;
        start_i = 1'b0;
        check("idle_after_ack", 64'({busy_o, done_o}), 64'd0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [63:0] saved;
        logic        saw_done;
        checks = 0; failures = 0;
        rst_i = 1'b1; start_i = 1'b1; kill_i = 1'b0; ack_i = 1'b0;
        op_i = '0; word_i = 1'b0; a_i = '0; b_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("reset_stall", 64'(stall_o), 64'd0);
        check("reset_flags", 64'({busy_o, done_o}), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst_i = 1'b0; start_i = 1'b0;

        issue(3'd0, 1'b0, 64'd7, -64'd3, 0);
        issue(3'd3, 1'b0, '1, '1, 0);
        issue(3'd1, 1'b0, '1, '1, 0);
        issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
        issue(3'd7, 1'b0, 64'd5, 64'd0, 0);
        issue(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0);
        issue(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 0);
        issue(3'd2, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 4);

        // Squash in BUSY cycle 3 with start still asserted
        saved = result_o;
        @(negedge clk_i);
        start_i = 1'b1; op_i = 3'd4; word_i = 1'b0; a_i = 64'd1000; b_i = 64'd3;
        repeat (3) @(negedge clk_i);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0; start_i = 1'b0;
        check("kill_to_idle", 64'({busy_o, done_o}), 64'd0);
        saw_done = 1'b0;
        repeat (70) begin
            @(negedge clk_i);
            saw_done = saw_done | done_o;
        end
        check("kill_no_done", 64'(saw_done), 64'd0);
        check("kill_result_kept", result_o, saved);
        issue(3'd4, 1'b0, 64'd1000, 64'd3, 1);

        // Synchronous reset mid-operation discards the partial result
        @(negedge clk_i);
        start_i = 1'b1; op_i = 3'd0; word_i = 1'b0; a_i = 64'd9; b_i = 64'd9;
        repeat (4) @(negedge clk_i);
        start_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midop_reset_flags", 64'({busy_o, done_o}), 64'd0);
        check("midop_reset_result", result_o, 64'd0);

        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick(),
                  int'($urandom_range(0, 2)));
        end

        repeat (5) @(negedge clk_i);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
